// File: rtl/flit_inject_ni.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : flit_inject_ni
// Purpose  : Network-interface injector. Buffers an unstallable 20-bit flit
//            stream in a FIFO, tags each flit head/body/tail and injects it
//            into the local router port under credit-based flow control.
// Options  : PARITY_EN - adds output flit_par (even parity over flit_out),
//            registered alongside flit_out. Absent when undefined.
// Revision : 1.0 - initial release
// ============================================================================
module flit_inject_ni #(
  parameter int FLIT_W  = 20,  // payload width per flit
  parameter int PKT_LEN = 30,  // flits per packet (1..63)
  parameter int DEPTH   = 32,  // FIFO entries, power of 2, >= PKT_LEN
  parameter int CREDITS = 4    // router input-buffer slots (1..15)
) (
  input  logic              clk,
  input  logic              RST,          // asynchronous, active low
  input  logic [FLIT_W-1:0] din,
  input  logic              din_valid,
  input  logic              credit_in,
  output logic [FLIT_W+1:0] flit_out,     // {type[1:0], payload}
  output logic              flit_valid,
  output logic [5:0]        fifo_count,
  output logic              overflow,
  output logic              busy
`ifdef PARITY_EN
  ,
  output logic              flit_par
`endif
);

  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [5:0] c_depth   = 6'(DEPTH);
  localparam logic [5:0] c_last    = 6'(PKT_LEN - 1);
  localparam logic [3:0] c_credits = 4'(CREDITS);
  localparam bit         c_single  = (PKT_LEN == 1);

  // Flit type codes carried in the two MSBs of flit_out
  localparam logic [1:0] c_ty_body   = 2'b00;
  localparam logic [1:0] c_ty_head   = 2'b01;
  localparam logic [1:0] c_ty_tail   = 2'b10;
  localparam logic [1:0] c_ty_single = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [5:0]        count_q, count_d;

  // Injection control
  logic [3:0]        credit_q, credit_d;
  logic [5:0]        idx_q, idx_d;
  state_t            state_q, state_d;

  // Registered outputs
  logic [FLIT_W+1:0] flit_out_q, flit_out_d;
  logic              flit_valid_q, flit_valid_d;
  logic              overflow_q, overflow_d;
`ifdef PARITY_EN
  logic              flit_par_q, flit_par_d;
`endif

  // Per-cycle decisions
  logic              w_send;
  logic              w_write;
  logic              w_tail;
  logic [1:0]        w_type;

  // Send and write decisions, all taken on pre-edge state
  always_comb begin
    w_send  = (count_q != 6'd0) && (credit_q != 4'd0);
    // A full FIFO still accepts a write when the head is popped this cycle
    w_write = din_valid && ((count_q != c_depth) || w_send);
    w_tail  = (idx_q == c_last);
    if (c_single) begin
      w_type = c_ty_single;
    end else if (idx_q == 6'd0) begin
      w_type = c_ty_head;
    end else if (w_tail) begin
      w_type = c_ty_tail;
    end else begin
      w_type = c_ty_body;
    end
  end

  // FIFO pointer, occupancy and overflow next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (w_write) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (w_send) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({w_write, w_send})
      2'b10:   count_d = count_q + 6'd1;
      2'b01:   count_d = count_q - 6'd1;
      default: count_d = count_q;
    endcase
    // Sticky: the source cannot be stalled, so a drop must be reported
    if (din_valid && !w_write) begin
      overflow_d = 1'b1;
    end
  end

  // Credit counter: spend on send, refill on credit_in, saturate at maximum
  always_comb begin
    credit_d = credit_q;
    case ({w_send, credit_in})
      2'b10:   credit_d = credit_q - 4'd1;
      2'b01:   credit_d = (credit_q == c_credits) ? credit_q : credit_q + 4'd1;
      default: credit_d = credit_q;
    endcase
  end

  // Packet flit index and injection state machine
  always_comb begin
    idx_d   = idx_q;
    state_d = state_q;
    if (w_send) begin
      idx_d = w_tail ? 6'd0 : idx_q + 6'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (w_send) begin
          state_d = w_tail ? ST_IDLE : ST_SEND;
        end
      end
      ST_SEND, ST_STALL: begin
        if (w_send) begin
          state_d = w_tail ? ST_IDLE : ST_SEND;
        end else begin
          state_d = ST_STALL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register: capture the tagged head entry on a send, else hold
  always_comb begin
    flit_valid_d = w_send;
    flit_out_d   = flit_out_q;
    if (w_send) begin
      flit_out_d = {w_type, mem_q[rd_ptr_q]};
    end
`ifdef PARITY_EN
    flit_par_d = flit_par_q;
    if (w_send) begin
      flit_par_d = ^flit_out_d;
    end
`endif
  end

  // FIFO storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (w_write) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= 6'd0;
      credit_q     <= c_credits;
      idx_q        <= 6'd0;
      state_q      <= ST_IDLE;
      flit_out_q   <= '0;
      flit_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef PARITY_EN
      flit_par_q   <= 1'b0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      credit_q     <= credit_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      flit_out_q   <= flit_out_d;
      flit_valid_q <= flit_valid_d;
      overflow_q   <= overflow_d;
`ifdef PARITY_EN
      flit_par_q   <= flit_par_d;
`endif
    end
  end

  assign flit_out   = flit_out_q;
  assign flit_valid = flit_valid_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != ST_IDLE) || (count_q != 6'd0);
`ifdef PARITY_EN
  assign flit_par   = flit_par_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_flit_inject_ni.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_flit_inject_ni
// Purpose  : Self-checking bench for flit_inject_ni: per-cycle vector table
//            plus directed multi-cycle sequences (bursts, stall, overflow,
//            coincident credits, mid-packet reset, optional parity).
// Revision : 1.0 - initial release
// ============================================================================
module tb_flit_inject_ni;

  localparam int PKT_LEN = 30;

  logic        clk = 1'b0;
  logic        RST;
  logic [19:0] din;
  logic        din_valid;
  logic        credit_in;
  logic [21:0] flit_out;
  logic        flit_valid;
  logic [5:0]  fifo_count;
  logic        overflow;
  logic        busy;
`ifdef PARITY_EN
  logic        flit_par;
`endif

  always #5 clk = ~clk;

  flit_inject_ni dut (
    .clk        (clk),
    .RST        (RST),
    .din        (din),
    .din_valid  (din_valid),
    .credit_in  (credit_in),
    .flit_out   (flit_out),
    .flit_valid (flit_valid),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .busy       (busy)
`ifdef PARITY_EN
    ,
    .flit_par   (flit_par)
`endif
  );

  int          total = 0;
  int          bad   = 0;
  logic [19:0] src[$];
  logic [21:0] rx[$];
  logic        rxp[$];
  logic [2:0]  cpipe;
  bit          auto_credit;
  logic        manual_credit;
  int          peak;

  typedef struct {
    logic        dv;
    logic [19:0] d;
    logic        ci;
    logic        ev;
    logic [21:0] eo;
    logic [5:0]  ec;
    logic        eb;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_type(input int i);
    int k;
    k = i % PKT_LEN;
    if (k == 0) return 2'b01;
    if (k == PKT_LEN - 1) return 2'b10;
    return 2'b00;
  endfunction

  // One clock: feed next queued payload, drive credit, collect any output flit
  task automatic tick();
    if (src.size() > 0) begin
      din       = src.pop_front();
      din_valid = 1'b1;
    end else begin
      din_valid = 1'b0;
    end
    credit_in     = auto_credit ? cpipe[1] : manual_credit;
    manual_credit = 1'b0;
    @(posedge clk);
    #1;
    cpipe = {cpipe[1:0], flit_valid};
    if (flit_valid) begin
      rx.push_back(flit_out);
`ifdef PARITY_EN
      rxp.push_back(flit_par);
`endif
    end
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
  endtask

  // Asynchronous reset pulse with immediate output check
  task automatic do_reset();
    #2;
    RST = 1'b0;
    #1;
    chk("rst_flit_out",   32'(flit_out),   32'd0);
    chk("rst_flit_valid", 32'(flit_valid), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_overflow",   32'(overflow),   32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
`ifdef PARITY_EN
    chk("rst_flit_par",   32'(flit_par),   32'd0);
`endif
    din_valid = 1'b0;
    credit_in = 1'b0;
    @(posedge clk);
    #1;
    RST = 1'b1;
    src.delete();
    rx.delete();
    rxp.delete();
    cpipe         = 3'b000;
    auto_credit   = 1'b0;
    manual_credit = 1'b0;
    peak          = 0;
  endtask

  // Check the received flits: payload base+i in order, type by position
  task automatic check_stream(input string tag, input int n, input int base);
    chk({tag, "_count"}, 32'(rx.size()), 32'(n));
    for (int i = 0; i < n && i < rx.size(); i++) begin
      chk($sformatf("%s_flit%0d", tag, i), 32'(rx[i]), 32'({exp_type(i), 20'(base + i)}));
    end
  endtask

  initial begin
    int nv;
    RST           = 1'b1;
    din           = 20'd0;
    din_valid     = 1'b0;
    credit_in     = 1'b0;
    cpipe         = 3'b000;
    auto_credit   = 1'b0;
    manual_credit = 1'b0;
    peak          = 0;

    // Per-cycle vectors from reset: {dv, din, credit_in, exp valid, exp out, exp count, exp busy}
    tbl[0] = '{1'b1, 20'hAAAAA, 1'b0, 1'b0, 22'h000000, 6'd1, 1'b1};
    tbl[1] = '{1'b1, 20'h12345, 1'b0, 1'b1, 22'h1AAAAA, 6'd1, 1'b1};
    tbl[2] = '{1'b0, 20'h00000, 1'b0, 1'b1, 22'h012345, 6'd0, 1'b1};
    tbl[3] = '{1'b0, 20'h00000, 1'b0, 1'b0, 22'h012345, 6'd0, 1'b1};
    tbl[4] = '{1'b0, 20'h00000, 1'b1, 1'b0, 22'h012345, 6'd0, 1'b1};
    tbl[5] = '{1'b0, 20'h00000, 1'b1, 1'b0, 22'h012345, 6'd0, 1'b1};
    tbl[6] = '{1'b0, 20'h00000, 1'b1, 1'b0, 22'h012345, 6'd0, 1'b1};

    do_reset();

    for (int i = 0; i < 7; i++) begin
      din_valid = tbl[i].dv;
      din       = tbl[i].d;
      credit_in = tbl[i].ci;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(flit_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_out", i),   32'(flit_out),   32'(tbl[i].eo));
      chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(tbl[i].ec));
      chk($sformatf("vec%0d_busy", i),  32'(busy),       32'(tbl[i].eb));
      chk($sformatf("vec%0d_ovf", i),   32'(overflow),   32'd0);
    end
    din_valid = 1'b0;
    credit_in = 1'b0;

    // Credits refilled to 4 with one extra pulse: exactly 4 more flits go out
    for (int i = 0; i < 6; i++) src.push_back(20'(200 + i));
    repeat (12) tick();
    chk("sat_sent", 32'(rx.size()), 32'd4);
    chk("sat_count", 32'(fifo_count), 32'd2);
    chk("sat_busy", 32'(busy), 32'd1);

    // Reset mid-packet with flits buffered: next flit out is a fresh head
    do_reset();
    src.push_back(20'h55555);
    repeat (4) tick();
    chk("midrst_sent", 32'(rx.size()), 32'd1);
    if (rx.size() > 0) chk("midrst_head", 32'(rx[0]), 32'h155555);

    // Full packet with credits returned two cycles after each flit
    do_reset();
    for (int i = 0; i < 30; i++) src.push_back(20'(i));
    auto_credit = 1'b1;
    for (int c = 0; c < 200 && rx.size() < 30; c++) tick();
    chk("burst_busy_after_tail", 32'(busy), 32'd0);
    repeat (4) tick();
    check_stream("burst", 30, 0);
    chk("burst_overflow", 32'(overflow), 32'd0);
    chk("burst_count", 32'(fifo_count), 32'd0);

    // No credit return: 4 flits then stall, FIFO peaks at 26, then drain
    do_reset();
    for (int i = 0; i < 30; i++) src.push_back(20'(i));
    repeat (40) tick();
    chk("stall_sent", 32'(rx.size()), 32'd4);
    chk("stall_peak", 32'(peak), 32'd26);
    chk("stall_count", 32'(fifo_count), 32'd26);
    for (int i = 0; i < 26; i++) begin
      manual_credit = 1'b1;
      tick();
    end
    for (int c = 0; c < 20 && rx.size() < 30; c++) tick();
    check_stream("drain", 30, 0);
    chk("drain_count", 32'(fifo_count), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);

    // Overflow: 40 flits, no credits -> 4 sent, 32 held, last 4 dropped
    do_reset();
    for (int i = 0; i < 40; i++) src.push_back(20'(100 + i));
    repeat (50) tick();
    chk("ovf_sent", 32'(rx.size()), 32'd4);
    chk("ovf_count", 32'(fifo_count), 32'd32);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 32; i++) begin
      manual_credit = 1'b1;
      tick();
    end
    repeat (5) tick();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_drain_count", 32'(fifo_count), 32'd0);
    check_stream("ovf", 36, 100);

    // Credit returned in the same cycle as each send at credits=1
    do_reset();
    for (int i = 0; i < 3; i++) src.push_back(20'(300 + i));
    repeat (6) tick();
    for (int i = 0; i < 8; i++) src.push_back(20'(303 + i));
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      manual_credit = (i >= 1 && i <= 8);
      tick();
      if (i >= 1 && i <= 8 && flit_valid) nv++;
    end
    chk("coinc_back_to_back", 32'(nv), 32'd8);
    for (int i = 0; i < 3; i++) src.push_back(20'(311 + i));
    repeat (8) tick();
    check_stream("coinc", 12, 300);
    chk("coinc_count", 32'(fifo_count), 32'd2);

    // Credit pulses while idle at full credit are ignored
    do_reset();
    manual_credit = 1'b1;
    tick();
    manual_credit = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) src.push_back(20'(400 + i));
    repeat (12) tick();
    chk("idle_credit_sent", 32'(rx.size()), 32'd4);

`ifdef PARITY_EN
    do_reset();
    src.push_back(20'h00001);
    src.push_back(20'h00003);
    src.push_back(20'h00007);
    repeat (6) tick();
    chk("par_sent", 32'(rx.size()), 32'd3);
    if (rx.size() >= 3) begin
      chk("par_head_out", 32'(rx[0]), 32'h100001);
      chk("par_head", 32'(rxp[0]), 32'd0);
      chk("par_body3", 32'(rxp[1]), 32'd0);
      chk("par_body7", 32'(rxp[2]), 32'd1);
    end
`endif

    // Final reset also confirms overflow and busy clear
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
